// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and datapath signal bundle for alu_cmd_sequencer.
// master is the sequencer's view; slave is the surrounding environment's view.
interface alu_cmd_sequencer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic [1:0]       dp_aluop;
  logic [WIDTH-1:0] dp_result;
  logic             dp_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, dp_result, dp_zero, rsp_ready,
    output cmd_ready, dp_a, dp_b, dp_aluop, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, dp_result, dp_zero, rsp_ready,
    input  cmd_ready, dp_a, dp_b, dp_aluop, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-side controller for a 4-op ALU datapath: single-cycle ops, equality compare,
// and multiply by repeated ADD, with valid/ready command and response channels.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

  localparam logic [2:0] OpCmp = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             cmd_ready;
  logic [WIDTH-1:0] dp_a, dp_b;
  logic [1:0]       dp_aluop;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    // Gated by rst_n so no command is taken while reset is being applied.
    cmd_ready  = (state_q == StIdle) && rst_n;
    dp_a       = '0;
    dp_b       = '0;
    dp_aluop   = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready) begin
          op_d = bus.cmd_op;
          a_d  = bus.cmd_a;
          b_d  = bus.cmd_b;
          if (bus.cmd_op > OpMul) begin
            rsp_data_d = '0;
            rsp_zero_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = StResp;
          end else if (bus.cmd_op == OpMul && bus.cmd_b == '0) begin
            rsp_data_d = '0;
            rsp_zero_d = 1'b1;
            rsp_err_d  = 1'b0;
            state_d    = StResp;
          end else if (bus.cmd_op == OpMul) begin
            acc_d   = '0;
            cnt_d   = bus.cmd_b;
            state_d = StMul;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        dp_a       = a_q;
        dp_b       = b_q;
        dp_aluop   = (op_q == OpCmp) ? 2'b01 : op_q[1:0];
        rsp_data_d = (op_q == OpCmp) ? '0 : bus.dp_result;
        rsp_zero_d = bus.dp_zero;
        rsp_err_d  = 1'b0;
        state_d    = StResp;
      end
      StMul: begin
        // acc accumulates a_q once per remaining count; wraps mod 2^WIDTH.
        dp_a  = acc_q;
        dp_b  = a_q;
        acc_d = bus.dp_result;
        cnt_d = cnt_q - WIDTH'(1);
        if (cnt_q == WIDTH'(1)) begin
          rsp_data_d = bus.dp_result;
          rsp_zero_d = bus.dp_zero;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.dp_a      = dp_a;
  assign bus.dp_b      = dp_b;
  assign bus.dp_aluop  = dp_aluop;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
